viterbi_frame_ctrl: RTL

Frame sequencer and BER scheduler for the convolutional encoder -> channel -> Viterbi decoder datapath. On start it drives a PRBS frame plus zero tail into the encoder and schedules burst error injection for the channel stage. It compares decoder output against a latency-aligned reference copy of the data and reports bit and error counts. It replaces free-running testbench stimulus and $random-driven injection with a deterministic, reproducible controller.

---
 rtl/viterbi_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_frame_ctrl
// Description : Frame sequencer and burst-error scheduler for the
//               encoder -> channel -> Viterbi decoder datapath. Emits a PRBS
//               frame plus zero tail and schedules channel bit-flip bursts.
//               It also checks decoder output against a latency-aligned
//               reference copy of the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 8,
    parameter int ENC_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [7:0]  inj_period,
    input  logic [2:0]  burst_len,
    input  logic [1:0]  inj_mask,
    input  logic        decoder_o,
    output logic        encoder_i,
    output logic        enable_encoder_i,
    output logic [1:0]  chan_mask,
    output logic        busy,
    output logic        done,
    output logic [15:0] bit_count,
    output logic [15:0] err_count
);

    localparam int              CNT_W          = 17;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_data_last   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_tail_last   = CNT_W'(TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] c_drain_last  = CNT_W'(DEC_LAT - 1);
    localparam logic [15:0]      c_lfsr_default = 16'hACE1;
    localparam logic [15:0]      c_cnt16_one    = 16'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_TAIL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // With no tail the frame goes straight from data to drain.
    localparam state_t c_after_data = (TAIL_LEN > 0) ? S_TAIL : S_DRAIN;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_accept;

    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_adv;
    logic [15:0]        w_lfsr_next;

    logic [7:0]         r_period;
    logic [2:0]         r_blen;
    logic [1:0]         r_mask;
    logic [7:0]         w_period;
    logic [2:0]         w_blen;
    logic [1:0]         w_mask;

    logic [7:0]         r_sc;
    logic [7:0]         w_sc_next;
    logic [2:0]         r_brem;
    logic [2:0]         w_brem_next;
    logic [1:0]         r_sym_mask;
    logic [1:0]         w_sym_mask_next;
    logic               w_en_now;
    logic               w_en_next;
    logic               w_inj_on;
    logic               w_burst_start_next;

    logic [DEC_LAT-1:0] r_ref_v;
    logic [DEC_LAT-1:0] r_ref_b;

    assign w_lfsr_adv = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // Configuration seen this cycle: the live inputs on the accepting edge, latched copy otherwise.
    assign w_period = w_accept ? inj_period : r_period;
    assign w_blen   = w_accept ? burst_len  : r_blen;
    assign w_mask   = w_accept ? inj_mask   : r_mask;

    // Next-state, phase counter and LFSR sequencing.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_lfsr_next  = r_lfsr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_lfsr_next  = (seed == 16'h0000) ? c_lfsr_default : seed;
                end
            end
            S_DATA: begin
                w_lfsr_next = w_lfsr_adv;
                if (r_cnt == c_data_last) begin
                    w_cnt_next   = '0;
                    w_state_next = c_after_data;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            S_TAIL: begin
                if (r_cnt == c_tail_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DRAIN;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            S_DRAIN: begin
                if (r_cnt == c_drain_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State register plus registered control outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_lfsr           <= c_lfsr_default;
            r_period         <= '0;
            r_blen           <= '0;
            r_mask           <= '0;
            encoder_i        <= 1'b0;
            enable_encoder_i <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_lfsr           <= w_lfsr_next;
            r_period         <= w_period;
            r_blen           <= w_blen;
            r_mask           <= w_mask;
            encoder_i        <= (w_state_next == S_DATA) & w_lfsr_next[0];
            enable_encoder_i <= (w_state_next == S_DATA) || (w_state_next == S_TAIL);
            busy             <= (w_state_next == S_DATA) || (w_state_next == S_TAIL) ||
                                (w_state_next == S_DRAIN);
            done             <= (w_state_next == S_DONE);
        end
    end

    // Burst scheduler: everything is computed one symbol ahead so the mask is a register.
    assign w_en_now  = (r_state == S_DATA) || (r_state == S_TAIL);
    assign w_en_next = (w_state_next == S_DATA) || (w_state_next == S_TAIL);
    assign w_inj_on  = (w_period != 8'd0) && (w_blen != 3'd0);

    always_comb begin
        w_sc_next = r_sc;
        if (w_accept) begin
            // The accepting edge counts as the first step, so symbol 1 sees sc = 1 mod period.
            w_sc_next = (w_period == 8'd1) ? 8'd0 : 8'd1;
        end else if (w_en_now) begin
            w_sc_next = (r_sc == (r_period - 8'd1)) ? 8'd0 : (r_sc + 8'd1);
        end
    end

    assign w_burst_start_next = w_en_next && w_inj_on && (w_sc_next == (w_period - 8'd1));

    always_comb begin
        w_brem_next     = 3'd0;
        w_sym_mask_next = 2'b00;
        if (w_en_next) begin
            if (w_burst_start_next) begin
                w_brem_next = w_blen - 3'd1;
            end else if (r_brem != 3'd0) begin
                w_brem_next = r_brem - 3'd1;
            end
            if (w_burst_start_next || (r_brem != 3'd0)) begin
                w_sym_mask_next = w_mask;
            end
        end
    end

    // Scheduler registers: symbol counter, remaining burst length, current symbol mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc       <= '0;
            r_brem     <= '0;
            r_sym_mask <= '0;
        end else begin
            r_sc       <= w_sc_next;
            r_brem     <= w_brem_next;
            r_sym_mask <= w_sym_mask_next;
        end
    end

    // Mask delay that lines the scheduler output up with the encoder output symbol.
    generate
        if (ENC_LAT == 0) begin : g_mask_direct
            assign chan_mask = r_sym_mask;
        end else begin : g_mask_pipe
            logic [1:0] r_mask_dly [ENC_LAT];

            // Shift the per-symbol mask through ENC_LAT stages.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < ENC_LAT; i++) begin
                        r_mask_dly[i] <= 2'b00;
                    end
                end else begin
                    r_mask_dly[0] <= r_sym_mask;
                    for (int i = 1; i < ENC_LAT; i++) begin
                        r_mask_dly[i] <= r_mask_dly[i-1];
                    end
                end
            end

            assign chan_mask = r_mask_dly[ENC_LAT-1];
        end
    endgenerate

    // Reference delay line and bit/error counters; only data bits are ever counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_v   <= '0;
            r_ref_b   <= '0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            r_ref_v[0] <= (r_state == S_DATA);
            r_ref_b[0] <= encoder_i;
            for (int i = 1; i < DEC_LAT; i++) begin
                r_ref_v[i] <= r_ref_v[i-1];
                r_ref_b[i] <= r_ref_b[i-1];
            end
            if (w_accept) begin
                bit_count <= '0;
                err_count <= '0;
            end else if (r_ref_v[DEC_LAT-1]) begin
                bit_count <= bit_count + c_cnt16_one;
                if ((decoder_o != r_ref_b[DEC_LAT-1]) && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + c_cnt16_one;
                end
            end
        end
    end

endmodule
`default_nettype wire
